// File: rtl/top_prod_rescale.sv
// Two-stage rescale of a wide unsigned product: shift (S1), then round and saturate (S2).
// Define TOP_RESCALE_ROUND_EN for round-half-up; otherwise the result is truncated.
module top_prod_rescale #(
    parameter int IN_W  = 96,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic [6:0]       in_shift,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    // Handshake: a word moves on valid & ready at a rising edge. Both stages
    // advance together whenever S2 is empty or being drained; in_ready is that enable.
    localparam logic [6:0] MAX_SH = 7'(IN_W - 1);

    logic             adv;
    logic [6:0]       shift_eff;
    logic             s1_valid_q;
    logic [IN_W-1:0]  s1_data_q, s1_data_d;
    logic [IN_W:0]    sum;
    logic             sat_d;
    logic [OUT_W-1:0] out_data_d;
    logic             out_valid_q, out_sat_q;
    logic [OUT_W-1:0] out_data_q;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        shift_eff = (in_shift > MAX_SH) ? MAX_SH : in_shift;
        s1_data_d = in_data >> shift_eff;
    end

`ifdef TOP_RESCALE_ROUND_EN
    logic s1_rnd_q, s1_rnd_d;

    always_comb begin
        s1_rnd_d = 1'b0;
        if (shift_eff != 7'd0) s1_rnd_d = in_data[shift_eff - 7'd1];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)   s1_rnd_q <= 1'b0;
        else if (adv) s1_rnd_q <= s1_rnd_d;
    end

    assign sum = {1'b0, s1_data_q} + (IN_W + 1)'(s1_rnd_q);
`else
    assign sum = {1'b0, s1_data_q};
`endif

    // Anything at or above bit OUT_W means the value does not fit the output.
    always_comb begin
        sat_d      = |sum[IN_W:OUT_W];
        out_data_d = sat_d ? '1 : sum[OUT_W-1:0];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s1_data_q   <= s1_data_d;
            out_valid_q <= s1_valid_q;
            out_data_q  <= out_data_d;
            out_sat_q   <= sat_d;
        end
    end

    // Clear beats a same-cycle increment; the count sticks at its maximum.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1))
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_top_prod_rescale.sv
// Directed bench for top_prod_rescale; expectations follow TOP_RESCALE_ROUND_EN when defined.
module tb_top_prod_rescale;

    localparam int IN_W  = 96;
    localparam int OUT_W = 32;
    localparam int CNT_W = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic [IN_W-1:0]  in_data = '0;
    logic [6:0]       in_shift = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [OUT_W-1:0] exp_q[$];

    localparam logic [IN_W-1:0] SAT_IN = 96'h1_0000_0000;

    top_prod_rescale #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_data  (in_data),
        .in_shift (in_shift),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat_cnt  (sat_cnt),
        .sat_clr  (sat_clr)
    );

    always #5 ap_clk = ~ap_clk;

    // Sends one word and returns at the falling edge where its result is on the output.
    task automatic drive_single(input logic [IN_W-1:0] d, input logic [6:0] sh);
        @(posedge ap_clk); #1;
        in_data = d; in_shift = sh; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL rst_out_sat got=%b exp=0", out_sat); end
        n_cmp++; if (sat_cnt !== '0) begin n_err++; $display("FAIL rst_sat_cnt got=%h exp=0", sat_cnt); end
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_latency();
        logic [OUT_W-1:0] exp_d;
`ifdef TOP_RESCALE_ROUND_EN
        exp_d = 32'h2;
`else
        exp_d = 32'h1;
`endif
        @(posedge ap_clk); #1;
        in_data = 96'h1_8000_0000; in_shift = 7'd32; in_valid = 1'b1; out_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL lat_data got=%h exp=%h", out_data, exp_d); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL lat_sat got=%b exp=0", out_sat); end
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_bubble got=%b exp=0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [IN_W-1:0]  vd[6];
        logic [6:0]       vs[6];
        logic [OUT_W-1:0] ed[6];
        logic             es[6];
        vd[0] = SAT_IN;                vs[0] = 7'd0;   ed[0] = 32'hFFFF_FFFF; es[0] = 1'b1;
        vd[1] = 96'hFFFF_FFFF;         vs[1] = 7'd0;   ed[1] = 32'hFFFF_FFFF; es[1] = 1'b0;
        vd[2] = 96'h1234_5678_0000;    vs[2] = 7'd16;  ed[2] = 32'h1234_5678; es[2] = 1'b0;
`ifdef TOP_RESCALE_ROUND_EN
        vd[3] = 96'h1_FFFF_FFFF;       vs[3] = 7'd1;   ed[3] = 32'hFFFF_FFFF; es[3] = 1'b1;
        vd[4] = '1;                    vs[4] = 7'd120; ed[4] = 32'h2;         es[4] = 1'b0;
        vd[5] = 96'h8000;              vs[5] = 7'd16;  ed[5] = 32'h1;         es[5] = 1'b0;
`else
        vd[3] = 96'h1_FFFF_FFFF;       vs[3] = 7'd1;   ed[3] = 32'hFFFF_FFFF; es[3] = 1'b0;
        vd[4] = '1;                    vs[4] = 7'd120; ed[4] = 32'h1;         es[4] = 1'b0;
        vd[5] = 96'h8000;              vs[5] = 7'd16;  ed[5] = 32'h0;         es[5] = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            drive_single(vd[i], vs[i]);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid got=%b exp=1", i, out_valid); end
            n_cmp++; if (out_data !== ed[i]) begin n_err++; $display("FAIL vec%0d_data got=%h exp=%h", i, out_data, ed[i]); end
            n_cmp++; if (out_sat !== es[i]) begin n_err++; $display("FAIL vec%0d_sat got=%b exp=%b", i, out_sat, es[i]); end
            if (es[i]) exp_cnt = exp_cnt + 1'b1;
            @(posedge ap_clk);
            @(negedge ap_clk);
            n_cmp++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL vec%0d_cnt got=%h exp=%h", i, sat_cnt, exp_cnt); end
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [OUT_W-1:0] held = '0;
        logic stalled_prev = 1'b0;
        exp_q.delete();
        @(posedge ap_clk); #1;
        in_valid = 1'b1; in_data = 96'h1000; in_shift = 7'd4; out_ready = 1'b1;
        while (got < 8 && cyc < 60) begin
            @(negedge ap_clk);
            if (out_valid && !out_ready) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stream_stall_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            if (stalled_prev) begin
                n_cmp++; if (out_data !== held) begin n_err++; $display("FAIL stream_stable cyc=%0d got=%h exp=%h", cyc, out_data, held); end
            end
            stalled_prev = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(32'h100 + 32'(sent));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra got=%h exp=none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin n_err++; $display("FAIL stream_data got=%h exp=%h", out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            @(posedge ap_clk); #1;
            cyc++;
            in_valid  = (sent < 8);
            in_data   = 96'h1000 + 96'(sent) * 96'h10;
            out_ready = !(cyc >= 4 && cyc <= 6);
        end
        n_cmp++; if (got != 8) begin n_err++; $display("FAIL stream_count got=%0d exp=8", got); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_sat_cnt();
        @(posedge ap_clk); #1;
        sat_clr = 1'b1;
        @(posedge ap_clk); #1;
        sat_clr = 1'b0;
        @(negedge ap_clk);
        exp_cnt = '0;
        n_cmp++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL clr_alone got=%h exp=0", sat_cnt); end

        drive_single(SAT_IN, 7'd0);
        sat_clr = 1'b1;
        @(posedge ap_clk); #1;
        sat_clr = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if (sat_cnt !== '0) begin n_err++; $display("FAIL clr_prio_low got=%h exp=0", sat_cnt); end

        @(posedge ap_clk); #1;
        in_data = SAT_IN; in_shift = 7'd0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65535) @(posedge ap_clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (sat_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_preload got=%h exp=ffff", sat_cnt); end

        drive_single(SAT_IN, 7'd0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (sat_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_hold got=%h exp=ffff", sat_cnt); end

        drive_single(SAT_IN, 7'd0);
        sat_clr = 1'b1;
        @(posedge ap_clk); #1;
        sat_clr = 1'b0;
        @(negedge ap_clk);
        n_cmp++; if (sat_cnt !== '0) begin n_err++; $display("FAIL clr_prio_max got=%h exp=0", sat_cnt); end
    endtask

    task automatic test_async_reset();
        drive_single(SAT_IN, 7'd0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (sat_cnt !== 16'h1) begin n_err++; $display("FAIL ar_pre_cnt got=%h exp=1", sat_cnt); end
        @(posedge ap_clk); #1;
        in_data = SAT_IN; in_shift = 7'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge ap_clk); #1;
        in_data = 96'h5_0000_0000;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ar_inflight got=%b exp=1", out_valid); end
        #1 ap_rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sat_cnt !== '0) begin n_err++; $display("FAIL ar_cnt got=%h exp=0", sat_cnt); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL ar_data got=%h exp=0", out_data); end
        n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL ar_sat got=%b exp=0", out_sat); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_stale%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_stream();
        test_sat_cnt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/top_prod_rescale.md
TOP_PROD_RESCALE -- requirements
Module: top_prod_rescale

Interface
REQ-001 SHALL have parameter IN_W, default 96, meaning width of the unsigned product input.
REQ-002 SHALL have parameter OUT_W, default 32, meaning width of the rescaled unsigned output.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the saturation event counter.
REQ-004 SHALL have port ap_clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port ap_rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, IN_W, meaning unsigned product from the 32x64 multiplier stage.
REQ-007 SHALL have port in_shift, input, 7, meaning right-shift amount, sampled with in_data.
REQ-008 SHALL have port in_valid, input, 1, meaning in_data/in_shift valid.
REQ-009 SHALL have port in_ready, output, 1, meaning stage accepts input this cycle.
REQ-010 SHALL have port out_data, output, OUT_W, meaning rescaled result.
REQ-011 SHALL have port out_sat, output, 1, meaning out_data was clamped; qualified by out_valid.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data/out_sat valid.
REQ-013 SHALL have port out_ready, input, 1, meaning downstream accepts output.
REQ-014 SHALL have port sat_cnt, output, CNT_W, meaning count of saturated outputs transferred.
REQ-015 SHALL have port sat_clr, input, 1, meaning synchronous clear of sat_cnt.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers shifted value and round bit; S2 registers rounded, saturated result.
REQ-017 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-018 Pipeline advance enable SHALL be (!out_valid | out_ready); in_ready SHALL equal that enable; S1 and S2 advance together when enabled and hold when not.
REQ-019 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput one result per cycle.
REQ-020 in_shift values above IN_W-1 SHALL be clamped to IN_W-1.
REQ-021 S1 SHALL compute q = in_data >> shift and r = bit (shift-1) of in_data when shift>0, else r=0.
REQ-022 S2 SHALL compute s = q + r at IN_W+1 bits, no wrap.
REQ-023 If s > 2^OUT_W-1, out_data SHALL be all ones and out_sat 1; else out_data = s[OUT_W-1:0], out_sat 0.
REQ-024 Bubbles (in_valid low while enabled) SHALL propagate as invalid slots; out_valid falls when a bubble reaches S2.
REQ-025 out_data/out_sat SHALL remain stable while out_valid&!out_ready.
REQ-026 sat_cnt SHALL increment by 1 on each output transfer with out_sat=1, holding at 2^CNT_W-1 (no wrap).
REQ-027 sat_clr SHALL set sat_cnt to 0 next cycle and SHALL take priority over a simultaneous increment.

Reset
REQ-028 On ap_rst high, out_valid, S1 valid, out_data, out_sat and sat_cnt SHALL become 0 immediately, without waiting for a clock edge.
REQ-029 In-flight data SHALL be discarded on reset; in_ready SHALL be 1 in the first cycle after ap_rst deasserts.

Configuration
REQ-030 With macro TOP_RESCALE_ROUND_EN defined, REQ-021 SHALL apply (round half up).
REQ-031 Without TOP_RESCALE_ROUND_EN, r SHALL be forced to 0 (truncation) and the round-bit logic SHALL be absent.

Verification
REQ-032 in_data=0x1_8000_0000, shift=32, out_ready=1 -> out_data=0x2 with ROUND_EN (0x1 without), out_sat=0, 2 cycles after input transfer.
REQ-033 in_data=0x1_0000_0000, shift=0 -> out_data=0xFFFFFFFF, out_sat=1, sat_cnt increments from 0 to 1.
REQ-034 Stream 8 inputs, out_ready low for 3 cycles mid-stream -> in_ready low while stalled, all 8 results in order, none lost or duplicated, out_data stable during stall.
REQ-035 Preload sat_cnt=0xFFFF via saturating inputs, send another saturating input -> sat_cnt stays 0xFFFF; assert sat_clr concurrently with a saturating transfer -> sat_cnt=0.
REQ-036 Assert ap_rst asynchronously with 2 results in flight -> out_valid=0 before next edge, sat_cnt=0, no stale output after release.
REQ-037 in_shift=120, in_data=all ones -> shift treated as 95, out_data=0x1 (ROUND_EN: 0x2 with round bit 1).
